// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the lab ALU datapath blocks.
// Used by serial_add_sub and its digit_adder slice.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
      logic n;
   } flags_t;

   function automatic int digit_count(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter is at least one bit wide even when a single digit covers the word.
   function automatic int count_width(input int width, input int digit);
      int ndig;
      ndig = width / digit;
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple-carry adder with carry in and carry out.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_sum,
   output logic             o_cout
);

   logic [DIGIT:0] w_carry;

   // NOTE: combinational logic uses blocking '=' so each bit sees the carry
   // computed for the bit below it in the same evaluation; defaults first avoid latches.
   always_comb begin
      w_carry    = '0;
      o_sum      = '0;
      w_carry[0] = i_cin;
      for (int i = 0; i < DIGIT; i++) begin
         o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
         w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout = w_carry[DIGIT];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, with C/V/Z/N flags.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp overflowed results to the signed limit.
module serial_add_sub
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             v,
   output logic             z,
   output logic             n
);

   localparam int            NDIG = digit_count(WIDTH, DIGIT);
   localparam int            CW   = count_width(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_a_msb;
   logic             r_b_msb;
   logic [WIDTH-1:0] r_s;
   flags_t           r_flags;

   logic             w_accept;
   logic             w_last;
   logic [DIGIT-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] w_s_final;
   logic             w_v;
   flags_t           w_flags;

   assign w_accept = start && (r_state != ST_BUSY);
   assign w_last   = (r_cnt == LAST);

   digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
      .i_a    (r_a[DIGIT-1:0]),
      .i_b    (r_b[DIGIT-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // w_result is the shift register contents after this cycle's digit enters at the MSB.
   if (DIGIT == WIDTH) begin : g_single
      assign w_result = w_sum;
   end else begin : g_shift
      logic [WIDTH-DIGIT-1:0] r_acc;
      always_ff @(posedge clk) begin
         if (r_state == ST_BUSY) r_acc <= w_result[WIDTH-1:DIGIT];
      end
      assign w_result = {w_sum, r_acc};
   end

   assign w_v = (r_a_msb == r_b_msb) && (w_result[WIDTH-1] != r_a_msb);

`ifdef SERIAL_ADD_SUB_SATURATE_EN
   assign w_s_final = !w_v     ? w_result :
                      r_a_msb  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_s_final = w_result;
`endif

   assign w_flags = '{c: w_cout, v: w_v, z: (w_s_final == '0), n: w_s_final[WIDTH-1]};

   // NOTE: operand registers carry no reset; they are always loaded on an accepted
   // start before being read, so resetting them would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (r_state == ST_BUSY) begin
         r_a <= r_a >> DIGIT;
         r_b <= r_b >> DIGIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_flags <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_state <= ST_BUSY;
                  r_busy  <= 1'b1;
                  r_carry <= sub;
                  r_cnt   <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_s     <= w_s_final;
                  r_flags <= w_flags;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign s    = r_s;
   assign c    = r_flags.c;
   assign v    = r_flags.v;
   assign z    = r_flags.z;
   assign n    = r_flags.n;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: four instances (W4/D1, W4/D2, W4/D4, W8/D2).
// Honours SERIAL_ADD_SUB_SATURATE_EN when computing expected results.
module tb_serial_add_sub;

   logic       clk;
   logic       rst_n;
   logic       start_v [4];
   logic       sub_v   [4];
   logic [7:0] a_in    [4];
   logic [7:0] b_in    [4];
   logic       busy_v  [4];
   logic       done_v  [4];
   logic       c_v     [4];
   logic       v_v     [4];
   logic       z_v     [4];
   logic       n_v     [4];
   logic [3:0] s0, s1, s2;
   logic [7:0] s3;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
      int         due;
   } exp_t;

   exp_t q0[$], q1[$], q2[$], q3[$];

   serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
      .a(a_in[0][3:0]), .b(b_in[0][3:0]), .busy(busy_v[0]), .done(done_v[0]),
      .s(s0), .c(c_v[0]), .v(v_v[0]), .z(z_v[0]), .n(n_v[0]));

   serial_add_sub #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
      .a(a_in[1][3:0]), .b(b_in[1][3:0]), .busy(busy_v[1]), .done(done_v[1]),
      .s(s1), .c(c_v[1]), .v(v_v[1]), .z(z_v[1]), .n(n_v[1]));

   serial_add_sub #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
      .a(a_in[2][3:0]), .b(b_in[2][3:0]), .busy(busy_v[2]), .done(done_v[2]),
      .s(s2), .c(c_v[2]), .v(v_v[2]), .z(z_v[2]), .n(n_v[2]));

   serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_v[3]),
      .a(a_in[3]), .b(b_in[3]), .busy(busy_v[3]), .done(done_v[3]),
      .s(s3), .c(c_v[3]), .v(v_v[3]), .z(z_v[3]), .n(n_v[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   function automatic int ndig(input int k);
      case (k)
         0:       return 4;
         1:       return 2;
         2:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int wd(input int k);
      return (k == 3) ? 8 : 4;
   endfunction

   function automatic logic [7:0] get_s(input int k);
      case (k)
         0:       return {4'h0, s0};
         1:       return {4'h0, s1};
         2:       return {4'h0, s2};
         default: return s3;
      endcase
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         2:       return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic void qpush(input int k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         2:       q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic exp_t qpop(input int k);
      case (k)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         2:       return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural signed/unsigned arithmetic model, independent of the digit structure.
   function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                  input logic sv);
      exp_t e;
      int mask, half, ua, ub, sa, sb, r, rs;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      ua   = int'(av) & mask;
      ub   = int'(bv) & mask;
      sa   = (ua >= half) ? ua - (1 << w) : ua;
      sb   = (ub >= half) ? ub - (1 << w) : ub;
      r    = sv ? sa - sb : sa + sb;
      e.v  = (r > half - 1) || (r < -half);
      e.c  = sv ? (ua >= ub) : (ua + ub >= (1 << w));
      rs   = r & mask;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
      if (e.v) rs = (sa < 0) ? half : half - 1;
`endif
      e.s   = 8'(rs);
      e.z   = (rs == 0);
      e.n   = ((rs >> (w - 1)) & 1) == 1;
      e.due = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (done_v[k] === 1'b1) begin
            if (qsize(k) == 0) begin
               check($sformatf("dut%0d_unexpected_done", k), 64'd1, 64'd0);
            end else begin
               e = qpop(k);
               check($sformatf("dut%0d_result_s_c_v_z_n", k),
                     {52'd0, get_s(k), c_v[k], v_v[k], z_v[k], n_v[k]},
                     {52'd0, e.s, e.c, e.v, e.z, e.n});
               check($sformatf("dut%0d_latency_cycle", k), 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   task automatic gap(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic wait_done(input int k);
      int waited;
      waited = 0;
      while (done_v[k] !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("dut%0d_done_within_bound", k), 64'(done_v[k]), 64'd1);
   endtask

   // Issued at a negedge; the following posedge accepts the operation.
   task automatic run_exp(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] es, input logic ec,
                          input logic ev, input logic ez, input logic en);
      exp_t e;
      e.s   = es;
      e.c   = ec;
      e.v   = ev;
      e.z   = ez;
      e.n   = en;
      e.due = cyc + 1 + ndig(k);
      a_in[k]    = av;
      b_in[k]    = bv;
      sub_v[k]   = sv;
      start_v[k] = 1'b1;
      qpush(k, e);
      @(posedge clk);
      @(negedge clk);
      start_v[k] = 1'b0;
      check($sformatf("dut%0d_busy_after_start", k), 64'(busy_v[k]), 64'd1);
      wait_done(k);
   endtask

   task automatic run_model(input int k, input logic [7:0] av, input logic [7:0] bv,
                            input logic sv);
      exp_t e;
      e = model(wd(k), av, bv, sv);
      run_exp(k, av, bv, sv, e.s, e.c, e.v, e.z, e.n);
   endtask

   task automatic exhaustive(input int k);
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int is = 0; is < 2; is++) begin
               run_model(k, 8'(ia), 8'(ib), is[0]);
               if (((ia + ib + is) % 5) == 0) gap(2);
            end
         end
      end
   endtask

   initial begin
      exp_t pend;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         start_v[k] = 1'b0;
         sub_v[k]   = 1'b0;
         a_in[k]    = 8'h00;
         b_in[k]    = 8'h00;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("dut%0d_reset_busy_done", k), {62'd0, busy_v[k], done_v[k]}, 64'd0);
         check($sformatf("dut%0d_reset_s", k), 64'(get_s(k)), 64'd0);
         check($sformatf("dut%0d_reset_flags", k), {60'd0, c_v[k], v_v[k], z_v[k], n_v[k]}, 64'd0);
      end
      rst_n = 1'b1;
      gap(1);

      // W4/D1 directed vectors; first one issued from IDLE, the rest back-to-back.
`ifdef SERIAL_ADD_SUB_SATURATE_EN
      run_exp(0, 8'h07, 8'h01, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      run_exp(0, 8'h07, 8'h01, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
      run_exp(0, 8'h08, 8'h01, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b1);
`else
      run_exp(0, 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 1'b1);
      run_exp(0, 8'h07, 8'h01, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
      run_exp(0, 8'h08, 8'h01, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
      gap(2);
      run_exp(0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run_exp(0, 8'h05, 8'h0B, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      // W8/D2: 100+27, then start held in DONE for 127+1, then subtractions.
      gap(2);
      run_exp(3, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADD_SUB_SATURATE_EN
      run_exp(3, 8'd127, 8'd1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
      run_exp(3, 8'h80, 8'd1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
`else
      run_exp(3, 8'd127, 8'd1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      run_exp(3, 8'h80, 8'd1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
      run_exp(3, 8'd50, 8'd100, 1'b1, 8'hCE, 1'b0, 1'b0, 1'b0, 1'b1);

      // Start pulsed in BUSY with other operands must be ignored: -1 + -2 = -3.
      gap(2);
      pend.s = 8'h0D; pend.c = 1'b1; pend.v = 1'b0; pend.z = 1'b0; pend.n = 1'b1;
      pend.due = cyc + 1 + ndig(0);
      a_in[0] = 8'h0F; b_in[0] = 8'h0E; sub_v[0] = 1'b0; start_v[0] = 1'b1;
      qpush(0, pend);
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      check("busy_cycle1", 64'(busy_v[0]), 64'd1);
      @(negedge clk);
      a_in[0] = 8'h07; b_in[0] = 8'h01; sub_v[0] = 1'b1; start_v[0] = 1'b1;
      check("busy_cycle2", 64'(busy_v[0]), 64'd1);
      @(negedge clk);
      start_v[0] = 1'b0;
      check("busy_cycle3_after_ignored_start", 64'(busy_v[0]), 64'd1);
      wait_done(0);

      // Reset for one edge in BUSY cycle 2 aborts the operation and clears outputs.
      gap(2);
      pend.s = 8'h0B; pend.c = 1'b0; pend.v = 1'b0; pend.z = 1'b0; pend.n = 1'b1;
      pend.due = cyc + 1 + ndig(0);
      a_in[0] = 8'h02; b_in[0] = 8'h07; sub_v[0] = 1'b1; start_v[0] = 1'b1;
      qpush(0, pend);
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
      check("abort_s", 64'(get_s(0)), 64'd0);
      check("abort_flags", {60'd0, c_v[0], v_v[0], z_v[0], n_v[0]}, 64'd0);
      rst_n = 1'b1;
      void'(q0.pop_back());
      gap(3);
      check("abort_no_late_done", 64'(done_v[0]), 64'd0);
      run_exp(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

      // Exhaustive W4 sweep on all three digit sizes in parallel.
      gap(2);
      fork
         exhaustive(0);
         exhaustive(1);
         exhaustive(2);
      join
      gap(4);

      for (int k = 0; k < 4; k++)
         check($sformatf("dut%0d_scoreboard_empty", k), 64'(qsize(k)), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
